z80_pin_mux: RTL and testbench

Z80_PIN_MUX -- requirements
Module: z80_pin_mux

---
 rtl/z80_pin_mux_if.sv | 21 ++
 rtl/z80_pin_mux.sv | 108 ++++++++++
 tb/tb_z80_pin_mux.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_pin_mux_if.sv
// Core-side bus of the Z80 pin multiplexer: address/data/control from the
// core, read data, synchronised control inputs and clock-enable back to it.
// master = Z80 core, slave = pin multiplexer.
interface z80_pin_mux_if;
    logic [15:0] cpu_addr;    // core address bus
    logic [7:0]  cpu_dout;    // core write data
    logic [7:0]  cpu_ctrl_n;  // {busak_n, halt_n, rfsh_n, wr_n, rd_n, iorq_n, mreq_n, m1_n}
    logic [7:0]  cpu_din;     // read data to the core
    logic [3:0]  cpu_in_n;    // registered {busrq_n, nmi_n, int_n, wait_n}
    logic        cpu_cen;     // one-cycle core clock-enable strobe

    modport master (
        output cpu_addr, cpu_dout, cpu_ctrl_n,
        input  cpu_din, cpu_in_n, cpu_cen
    );

    modport slave (
        input  cpu_addr, cpu_dout, cpu_ctrl_n,
        output cpu_din, cpu_in_n, cpu_cen
    );
endinterface

// File: rtl/z80_pin_mux.sv
// Time-multiplexes a Z80 core bus onto 8 dedicated + 8 bidirectional pins,
// one bus frame every PHASES (2 or 4) clocks; core advances once per frame.
// Latency: pins are combinational from phase; inputs registered one cycle.
// Backpressure: wait_n low in the last phase suppresses cpu_cen and repeats the frame.
// Ports: clk, rst_n (sync, active low), ena (design selected), ui_in (control
// inputs), uio_in (read data), uo_out/uio_out/uio_oe (pins), cpu (core bus).
module z80_pin_mux #(
    parameter int PHASES = 4    // supported values: 2 and 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [7:0]   ui_in,
    input  logic [7:0]   uio_in,
    output logic [7:0]   uo_out,
    output logic [7:0]   uio_out,
    output logic [7:0]   uio_oe,
    z80_pin_mux_if.slave cpu
);

    localparam logic [1:0] LAST = 2'(PHASES - 1);

    logic [1:0] phase_q;
    logic [3:0] in_q;
    logic [7:0] din_q;
    logic       rd_n;
    logic       wr_n;
    logic       cen;

    assign rd_n = cpu.cpu_ctrl_n[3];
    assign wr_n = cpu.cpu_ctrl_n[4];

    // Core steps only at the end of a frame and only when the bus is not held
    // by wait_n; rst_n gating keeps the strobe quiet throughout reset.
    assign cen = rst_n & ena & (phase_q == LAST) & in_q[0];

    assign cpu.cpu_cen  = cen;
    assign cpu.cpu_in_n = in_q;
    // The core samples the pins directly on its enable edge.
    assign cpu.cpu_din  = uio_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
            in_q    <= 4'hF;
            din_q   <= 8'h00;
        end else begin
            in_q <= ui_in[3:0];
            if (ena) begin
                phase_q <= (phase_q == LAST) ? 2'd0 : phase_q + 2'd1;
            end
            // Captured copy of read data, shown on the pins in the next frame.
            if (cen && !rd_n) begin
                din_q <= uio_in;
            end
        end
    end

    generate
        if (PHASES == 2) begin : g_two_phase
            // p0: addr lo + control on uio; p1: addr hi + write data on uio.
            always_comb begin
                uo_out  = 8'h00;
                uio_out = 8'h00;
                uio_oe  = 8'h00;
                if (rst_n && ena) begin
                    if (phase_q == 2'd0) begin
                        uo_out  = cpu.cpu_addr[7:0];
                        uio_out = cpu.cpu_ctrl_n;
                        uio_oe  = 8'hFF;
                    end else begin
                        uo_out = cpu.cpu_addr[15:8];
                        if (!wr_n) begin
                            uio_out = cpu.cpu_dout;
                            uio_oe  = 8'hFF;
                        end
                    end
                end
            end
        end else begin : g_four_phase
            // p0..p2: addr lo, addr hi, control; write data held on uio.
            // p3: last read data on uo, uio released so the bus can drive it.
            always_comb begin
                uo_out  = 8'h00;
                uio_out = 8'h00;
                uio_oe  = 8'h00;
                if (rst_n && ena) begin
                    case (phase_q)
                        2'd0:    uo_out = cpu.cpu_addr[7:0];
                        2'd1:    uo_out = cpu.cpu_addr[15:8];
                        2'd2:    uo_out = cpu.cpu_ctrl_n;
                        default: uo_out = din_q;
                    endcase
                    // Write wins over a simultaneous read for the uio drive.
                    if (phase_q != 2'd3 && !wr_n) begin
                        uio_out = cpu.cpu_dout;
                        uio_oe  = 8'hFF;
                    end
                end
            end
        end
    endgenerate

    // Reserved input pins.
    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in[7:4]};

endmodule

// File: tb/tb_z80_pin_mux.sv
module tb_z80_pin_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ena;
    logic [7:0]  ui_in;
    logic [7:0]  uio_in;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  ctrl_n;

    logic [7:0] uo4, uio_out4, oe4;
    logic [7:0] uo2, uio_out2, oe2;

    int checks   = 0;
    int failures = 0;

    z80_pin_mux_if if4();
    z80_pin_mux_if if2();

    assign if4.cpu_addr   = addr;
    assign if4.cpu_dout   = dout;
    assign if4.cpu_ctrl_n = ctrl_n;
    assign if2.cpu_addr   = addr;
    assign if2.cpu_dout   = dout;
    assign if2.cpu_ctrl_n = ctrl_n;

    z80_pin_mux #(.PHASES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo4), .uio_out(uio_out4), .uio_oe(oe4), .cpu(if4)
    );

    z80_pin_mux #(.PHASES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo2), .uio_out(uio_out2), .uio_oe(oe2), .cpu(if2)
    );

    // ---------------- behavioural reference model ----------------
    int         m_ph4, m_ph2;
    logic [3:0] m_in;
    logic [7:0] m_din4, m_din2;

    function automatic logic e_cen(input int phases, input int ph);
        return rst_n && ena && (ph == phases - 1) && m_in[0];
    endfunction

    function automatic logic [7:0] e_uo(input int phases, input int ph, input logic [7:0] din);
        logic [7:0] seq [4];
        if (!(rst_n && ena)) return 8'h00;
        seq = '{addr[7:0], addr[15:8], ctrl_n, din};
        return (phases == 2) ? seq[ph % 2] : seq[ph];
    endfunction

    function automatic logic [7:0] e_oe(input int phases, input int ph);
        if (!(rst_n && ena)) return 8'h00;
        if (phases == 2 && ph == 0) return 8'hFF;
        if (phases == 4 && ph == 3) return 8'h00;
        return ctrl_n[4] ? 8'h00 : 8'hFF;
    endfunction

    function automatic logic [7:0] e_uio(input int phases, input int ph);
        if (!(rst_n && ena)) return 8'h00;
        if (phases == 2 && ph == 0) return ctrl_n;
        if (phases == 4 && ph == 3) return 8'h00;
        return ctrl_n[4] ? 8'h00 : dout;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph4  <= 0;
            m_ph2  <= 0;
            m_in   <= 4'hF;
            m_din4 <= 8'h00;
            m_din2 <= 8'h00;
        end else begin
            if (e_cen(4, m_ph4) && !ctrl_n[3]) m_din4 <= uio_in;
            if (e_cen(2, m_ph2) && !ctrl_n[3]) m_din2 <= uio_in;
            m_in <= ui_in[3:0];
            if (ena) begin
                m_ph4 <= (m_ph4 + 1) % 4;
                m_ph2 <= (m_ph2 + 1) % 2;
            end
        end
    end

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'hA5;
        addr = 16'hFFFF; dout = 8'hFF; ctrl_n = 8'h00;
        @(negedge clk);
        checks++; if (uo4 !== 8'h00) begin failures++; $display("FAIL reset_uo4: got %h expected 00", uo4); end
        checks++; if (uio_out4 !== 8'h00) begin failures++; $display("FAIL reset_uio_out4: got %h expected 00", uio_out4); end
        checks++; if (oe4 !== 8'h00) begin failures++; $display("FAIL reset_oe4: got %h expected 00", oe4); end
        checks++; if (if4.cpu_cen !== 1'b0) begin failures++; $display("FAIL reset_cen4: got %b expected 0", if4.cpu_cen); end
        checks++; if (if4.cpu_in_n !== 4'hF) begin failures++; $display("FAIL reset_in_n4: got %h expected F", if4.cpu_in_n); end
        checks++; if (oe2 !== 8'h00) begin failures++; $display("FAIL reset_oe2: got %h expected 00", oe2); end
        checks++; if (uio_out2 !== 8'h00) begin failures++; $display("FAIL reset_uio_out2: got %h expected 00", uio_out2); end
        checks++; if (uo2 !== 8'h00) begin failures++; $display("FAIL reset_uo2: got %h expected 00", uo2); end
        step();
    endtask

    task automatic test_read();
        logic [7:0] tbl [4];
        ena = 1'b1; addr = 16'h1234; ctrl_n = 8'hF6; uio_in = 8'h5A; ui_in = 8'h0F; dout = 8'h99;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tbl = '{8'h34, 8'h12, 8'hF6, (c < 4) ? 8'h00 : 8'h5A};
            @(negedge clk);
            checks++; if (uo4 !== tbl[c % 4]) begin failures++; $display("FAIL read_uo c%0d: got %h expected %h", c, uo4, tbl[c % 4]); end
            checks++; if (oe4 !== 8'h00) begin failures++; $display("FAIL read_oe c%0d: got %h expected 00", c, oe4); end
            checks++; if (if4.cpu_cen !== 1'((c % 4) == 3)) begin failures++; $display("FAIL read_cen c%0d: got %b expected %b", c, if4.cpu_cen, (c % 4) == 3); end
            checks++; if (if4.cpu_din !== 8'h5A) begin failures++; $display("FAIL read_din c%0d: got %h expected 5A", c, if4.cpu_din); end
            step();
        end
    endtask

    task automatic test_write();
        logic [7:0] exp_p3;
        ena = 1'b1; addr = 16'h0F0F; dout = 8'hC3; ctrl_n = 8'hEF; uio_in = 8'h3C; ui_in = 8'h0F;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            ctrl_n = (c < 4) ? 8'hEF : 8'hE7;  // then rd_n and wr_n both low
            exp_p3 = (c < 8) ? 8'h00 : 8'h3C;
            @(negedge clk);
            checks++; if (oe4 !== ((c % 4 == 3) ? 8'h00 : 8'hFF)) begin failures++; $display("FAIL write_oe c%0d: got %h expected %h", c, oe4, (c % 4 == 3) ? 8'h00 : 8'hFF); end
            if (c % 4 != 3) begin
                checks++; if (uio_out4 !== 8'hC3) begin failures++; $display("FAIL write_uio c%0d: got %h expected C3", c, uio_out4); end
            end else begin
                checks++; if (uo4 !== exp_p3) begin failures++; $display("FAIL write_din c%0d: got %h expected %h", c, uo4, exp_p3); end
            end
            if (c % 4 == 2) begin
                checks++; if (uo4 !== ctrl_n) begin failures++; $display("FAIL write_ctrl c%0d: got %h expected %h", c, uo4, ctrl_n); end
            end
            step();
        end
    endtask

    task automatic test_wait();
        logic [7:0] tbl [4];
        int cens;
        tbl = '{8'h78, 8'h56, 8'hFF, 8'h00};
        cens = 0;
        ena = 1'b1; addr = 16'h5678; ctrl_n = 8'hFF; uio_in = 8'h11; dout = 8'h00; ui_in = 8'h0F;
        do_reset();
        ui_in = 8'h0E;
        for (int c = 0; c < 16; c++) begin
            if (c == 12) ui_in = 8'h0F;
            @(negedge clk);
            if (if4.cpu_cen === 1'b1) cens++;
            checks++; if (if4.cpu_cen !== 1'(c == 15)) begin failures++; $display("FAIL wait_cen c%0d: got %b expected %b", c, if4.cpu_cen, c == 15); end
            checks++; if (uo4 !== tbl[c % 4]) begin failures++; $display("FAIL wait_uo c%0d: got %h expected %h", c, uo4, tbl[c % 4]); end
            step();
        end
        checks++; if (cens != 1) begin failures++; $display("FAIL wait_cen_count: got %0d expected 1", cens); end
    endtask

    task automatic test_phase2();
        ena = 1'b1; addr = 16'hABCD; ctrl_n = 8'hFE; dout = 8'h55; uio_in = 8'h00; ui_in = 8'h0F;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (uo2 !== ((c % 2 == 0) ? 8'hCD : 8'hAB)) begin failures++; $display("FAIL p2_uo c%0d: got %h expected %h", c, uo2, (c % 2 == 0) ? 8'hCD : 8'hAB); end
            checks++; if (oe2 !== ((c % 2 == 0) ? 8'hFF : 8'h00)) begin failures++; $display("FAIL p2_oe c%0d: got %h expected %h", c, oe2, (c % 2 == 0) ? 8'hFF : 8'h00); end
            checks++; if (if2.cpu_cen !== 1'(c % 2 == 1)) begin failures++; $display("FAIL p2_cen c%0d: got %b expected %b", c, if2.cpu_cen, c % 2 == 1); end
            if (c % 2 == 0) begin
                checks++; if (uio_out2 !== 8'hFE) begin failures++; $display("FAIL p2_uio c%0d: got %h expected FE", c, uio_out2); end
            end
            step();
        end
    endtask

    task automatic test_ena_hold();
        ena = 1'b1; addr = 16'h2468; ctrl_n = 8'hEF; dout = 8'h81; uio_in = 8'h00; ui_in = 8'h0F;
        do_reset();
        step();  // now in p1
        ena = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (uo4 !== 8'h00 || oe4 !== 8'h00 || if4.cpu_cen !== 1'b0) begin failures++; $display("FAIL ena_off4 c%0d: got uo=%h oe=%h cen=%b expected 00/00/0", c, uo4, oe4, if4.cpu_cen); end
            checks++; if (uo2 !== 8'h00 || oe2 !== 8'h00 || if2.cpu_cen !== 1'b0) begin failures++; $display("FAIL ena_off2 c%0d: got uo=%h oe=%h cen=%b expected 00/00/0", c, uo2, oe2, if2.cpu_cen); end
            step();
        end
        ena = 1'b1;
        @(negedge clk);
        checks++; if (uo4 !== 8'h24) begin failures++; $display("FAIL ena_resume4: got %h expected 24", uo4); end
        checks++; if (uo2 !== 8'h24 || if2.cpu_cen !== 1'b1) begin failures++; $display("FAIL ena_resume2: got uo=%h cen=%b expected 24/1", uo2, if2.cpu_cen); end
        step();
        @(negedge clk);
        checks++; if (uo4 !== 8'hEF || oe4 !== 8'hFF) begin failures++; $display("FAIL ena_next4: got uo=%h oe=%h expected EF/FF", uo4, oe4); end
        step();
    endtask

    task automatic test_reset_mid();
        ena = 1'b1; addr = 16'h1357; ctrl_n = 8'hF7; dout = 8'h00; uio_in = 8'h77; ui_in = 8'h0F;
        do_reset();
        for (int c = 0; c < 7; c++) step();  // frame 1 p3
        @(negedge clk);
        checks++; if (uo4 !== 8'h77) begin failures++; $display("FAIL rmid_din_before: got %h expected 77", uo4); end
        step();
        ui_in = 8'h05;
        step(); step();  // p2
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (uo4 !== 8'h00 || uio_out4 !== 8'h00 || oe4 !== 8'h00 || if4.cpu_cen !== 1'b0) begin failures++; $display("FAIL rmid_outputs: got uo=%h uio=%h oe=%h cen=%b expected 00/00/00/0", uo4, uio_out4, oe4, if4.cpu_cen); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if4.cpu_in_n !== 4'hF) begin failures++; $display("FAIL rmid_in_n: got %h expected F", if4.cpu_in_n); end
        checks++; if (uo4 !== 8'h57) begin failures++; $display("FAIL rmid_p0: got %h expected 57", uo4); end
        step(); step(); step();
        @(negedge clk);
        checks++; if (uo4 !== 8'h00) begin failures++; $display("FAIL rmid_din_after: got %h expected 00", uo4); end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            ena    = ($urandom_range(0, 7) != 0);
            ui_in  = 8'($urandom);
            ui_in[0] = ($urandom_range(0, 3) != 0);
            uio_in = 8'($urandom);
            addr   = 16'($urandom);
            dout   = 8'($urandom);
            ctrl_n = 8'($urandom);
            @(negedge clk);
            checks++; if (uo4 !== e_uo(4, m_ph4, m_din4)) begin failures++; $display("FAIL rnd_uo4 c%0d: got %h expected %h", c, uo4, e_uo(4, m_ph4, m_din4)); end
            checks++; if (oe4 !== e_oe(4, m_ph4)) begin failures++; $display("FAIL rnd_oe4 c%0d: got %h expected %h", c, oe4, e_oe(4, m_ph4)); end
            checks++; if (uio_out4 !== e_uio(4, m_ph4)) begin failures++; $display("FAIL rnd_uio4 c%0d: got %h expected %h", c, uio_out4, e_uio(4, m_ph4)); end
            checks++; if (if4.cpu_cen !== e_cen(4, m_ph4)) begin failures++; $display("FAIL rnd_cen4 c%0d: got %b expected %b", c, if4.cpu_cen, e_cen(4, m_ph4)); end
            checks++; if (if4.cpu_in_n !== m_in) begin failures++; $display("FAIL rnd_in_n4 c%0d: got %h expected %h", c, if4.cpu_in_n, m_in); end
            checks++; if (if4.cpu_din !== uio_in) begin failures++; $display("FAIL rnd_din4 c%0d: got %h expected %h", c, if4.cpu_din, uio_in); end
            checks++; if (uo2 !== e_uo(2, m_ph2, m_din2)) begin failures++; $display("FAIL rnd_uo2 c%0d: got %h expected %h", c, uo2, e_uo(2, m_ph2, m_din2)); end
            checks++; if (oe2 !== e_oe(2, m_ph2)) begin failures++; $display("FAIL rnd_oe2 c%0d: got %h expected %h", c, oe2, e_oe(2, m_ph2)); end
            checks++; if (uio_out2 !== e_uio(2, m_ph2)) begin failures++; $display("FAIL rnd_uio2 c%0d: got %h expected %h", c, uio_out2, e_uio(2, m_ph2)); end
            checks++; if (if2.cpu_cen !== e_cen(2, m_ph2)) begin failures++; $display("FAIL rnd_cen2 c%0d: got %b expected %b", c, if2.cpu_cen, e_cen(2, m_ph2)); end
            checks++; if (if2.cpu_in_n !== m_in) begin failures++; $display("FAIL rnd_in_n2 c%0d: got %h expected %h", c, if2.cpu_in_n, m_in); end
            checks++; if (if2.cpu_din !== uio_in) begin failures++; $display("FAIL rnd_din2 c%0d: got %h expected %h", c, if2.cpu_din, uio_in); end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        addr = 16'h0000; dout = 8'h00; ctrl_n = 8'hFF;
        test_reset();
        test_read();
        test_write();
        test_wait();
        test_phase2();
        test_ena_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
